// File: rtl/gf8_pkg.sv
// rtl/gf8_pkg.sv - shared LFSR constants, next-state function and checker states
package gf8_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] TAP_MASK   = 8'h1B;
    localparam logic [LFSR_W-1:0] RESET_SEED = 8'hFF;

    typedef enum logic {
        HUNT,
        LOCKED
    } chk_state_t;

    // Right-shifting Fibonacci step; the new MSB is the XOR of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state);
        return {^(state & TAP_MASK), state[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with priority synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ranb_checker.sv
// rtl/ranb_checker.sv - self-synchronising checker for the 3-bit LFSR operand stream
module ranb_checker
    import gf8_pkg::*;
#(
    parameter int ERR_CNT_W   = 16,
    parameter int LOSS_THRESH = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [2:0]           b_in,
    input  logic                 b_valid,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [2:0]           pred
);

    localparam logic [3:0] THRESH = 4'(LOSS_THRESH);

    chk_state_t        state, state_d;
    logic [LFSR_W-1:0] a_q, a_d;
    logic [2:0]        fill_q, fill_d;
    logic [3:0]        consec_q, consec_d;
    logic              err_d;
    logic              inc_d;
    logic [2:0]        pred_d;

    always_comb begin
        state_d  = state;
        a_d      = a_q;
        fill_d   = fill_q;
        consec_d = consec_q;
        err_d    = 1'b0;
        inc_d    = 1'b0;
        if (b_valid) begin
            case (state)
                HUNT: begin
                    // Only b_in[2] carries a fresh bit; the fill counter wraps to 0 after 8.
                    a_d    = {b_in[2], a_q[LFSR_W-1:1]};
                    fill_d = fill_q + 3'd1;
                    if ((fill_q == 3'd7) && (a_d != '0)) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    a_d = lfsr_next(a_q);
                    if (b_in != pred) begin
                        err_d = 1'b1;
                        inc_d = 1'b1;
                        if ((consec_q + 4'd1) == THRESH) begin
                            state_d  = HUNT;
                            consec_d = '0;
                            fill_d   = '0;
                        end else begin
                            consec_d = consec_q + 4'd1;
                        end
                    end else begin
                        consec_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        // The shadow register trails the generator, so its top bits and feedback form the next sample.
        pred_d = {^(a_d & TAP_MASK), a_d[LFSR_W-1], a_d[LFSR_W-2]};
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= HUNT;
            a_q      <= '0;
            fill_q   <= '0;
            consec_q <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            pred     <= '0;
        end else begin
            state    <= state_d;
            a_q      <= a_d;
            fill_q   <= fill_d;
            consec_q <= consec_d;
            locked   <= (state_d == LOCKED);
            err      <= err_d;
            pred     <= pred_d;
        end
    end

    sat_counter #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .Clk(Clk),
        .Rst(Rst),
        .inc(inc_d),
        .clr(clr_cnt),
        .cnt(err_cnt)
    );

endmodule

// File: tb/tb_ranb_checker.sv
// tb/tb_ranb_checker.sv - randomized self-checking bench for ranb_checker
module tb_ranb_checker;
    import gf8_pkg::*;

    localparam int CW  = 4;
    localparam int THR = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [2:0]    b_in;
    logic          b_valid;
    logic          clr_cnt;
    logic          locked;
    logic          err;
    logic [CW-1:0] err_cnt;
    logic [2:0]    pred;

    always #5 Clk = ~Clk;

    ranb_checker #(
        .ERR_CNT_W(CW),
        .LOSS_THRESH(THR)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .b_in(b_in),
        .b_valid(b_valid),
        .clr_cnt(clr_cnt),
        .locked(locked),
        .err(err),
        .err_cnt(err_cnt),
        .pred(pred)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream generator
    logic [7:0] gen;
    function automatic logic [7:0] gen_adv(input logic [7:0] g);
        return {g[0] ^ g[1] ^ g[3] ^ g[4], g[7:1]};
    endfunction

    // Reference model: received bit history, extended by the recurrence x(n+8)=x(n)^x(n+1)^x(n+3)^x(n+4)
    bit m_locked;
    bit hq[$];
    int m_consec;
    int m_cnt;
    bit m_err;

    function automatic logic [2:0] m_next();
        return {hq[0] ^ hq[1] ^ hq[3] ^ hq[4], hq[7], hq[6]};
    endfunction

    task automatic model_reset();
        m_locked = 0;
        hq.delete();
        m_consec = 0;
        m_cnt    = 0;
        m_err    = 0;
    endtask

    task automatic model(input bit v, input logic [2:0] b, input bit c);
        bit inc;
        bit any;
        logic [2:0] e;
        inc   = 0;
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                hq.push_back(b[2]);
                if (hq.size() == 8) begin
                    any = 0;
                    foreach (hq[i]) any |= hq[i];
                    if (any) m_locked = 1;
                    else hq.delete();
                end
            end else begin
                e = m_next();
                if (b !== e) begin
                    m_err = 1;
                    inc   = 1;
                    m_consec++;
                end else begin
                    m_consec = 0;
                end
                if (m_consec == THR) begin
                    m_locked = 0;
                    m_consec = 0;
                    hq.delete();
                end else begin
                    hq.push_back(e[2]);
                    void'(hq.pop_front());
                end
            end
        end
        if (c) m_cnt = 0;
        else if (inc && m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    task automatic step(input bit v, input logic [2:0] b, input bit c, input string tag);
        b_valid = v;
        b_in    = b;
        clr_cnt = c;
        @(posedge Clk);
        #1;
        model(v, b, c);
        chk({tag, ".locked"}, locked, m_locked);
        chk({tag, ".err"}, err, m_err);
        chk({tag, ".err_cnt"}, err_cnt, m_cnt);
        if (m_locked) chk({tag, ".pred"}, pred, m_next());
        b_valid = 0;
        clr_cnt = 0;
    endtask

    task automatic feed(input bit v, input logic [2:0] mask, input bit c, input string tag);
        step(v, gen[2:0] ^ mask, c, tag);
        if (v) gen = gen_adv(gen);
    endtask

    task automatic do_reset(input bit reseed);
        b_valid = 0;
        clr_cnt = 0;
        Rst     = 1;
        @(posedge Clk);
        #1;
        Rst = 0;
        model_reset();
        if (reseed) gen = RESET_SEED;
        chk("rst.locked", locked, 0);
        chk("rst.err_cnt", err_cnt, 0);
    endtask

    logic [2:0] seq_tbl[8];

    initial begin
        Rst     = 0;
        b_valid = 0;
        b_in    = 0;
        clr_cnt = 0;
        gen     = RESET_SEED;
        model_reset();
        seq_tbl = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd3, 3'd1};

        // Power-on reset, checked before any clock edge
        #2 Rst = 1;
        #1;
        chk("por.locked", locked, 0);
        chk("por.err", err, 0);
        chk("por.err_cnt", err_cnt, 0);
        chk("por.pred", pred, 0);
        @(posedge Clk);
        #1 Rst = 0;

        // Lock on the seed-FF sequence
        for (int i = 0; i < 8; i++) begin
            chk("t1.gen", gen[2:0], seq_tbl[i]);
            feed(1, 3'd0, 0, "t1.fill");
        end
        chk("t1.locked", locked, 1);
        chk("t1.pred", pred, 0);
        chk("t1.next_sample", gen[2:0], 0);
        feed(1, 3'd0, 0, "t1.first");
        chk("t1.first_err", err, 0);

        // Single error
        for (int i = 0; i < 5; i++) feed(1, 3'd0, 0, "t2.pre");
        feed(1, 3'b100, 0, "t2.bad");
        chk("t2.err", err, 1);
        chk("t2.err_cnt", err_cnt, 1);
        chk("t2.locked", locked, 1);
        feed(1, 3'd0, 0, "t2.post");
        chk("t2.err_drop", err, 0);
        for (int i = 0; i < 10; i++) feed(1, 3'd0, 0, "t2.clean");

        // Loss of lock and relock
        for (int i = 0; i < 4; i++) feed(1, 3'b100, 0, "t3.bad");
        chk("t3.lost", locked, 0);
        chk("t3.err_cnt", err_cnt, 5);
        for (int i = 0; i < 7; i++) feed(1, 3'd0, 0, "t3.refill");
        chk("t3.not_yet", locked, 0);
        feed(1, 3'd0, 0, "t3.refill8");
        chk("t3.relock", locked, 1);
        chk("t3.cnt_kept", err_cnt, 5);
        for (int i = 0; i < 10; i++) feed(1, 3'd0, 0, "t3.clean");

        // Stalls: lock counted in valid samples only
        do_reset(1);
        for (int i = 0; i < 15; i++) feed(i % 2 == 0, 3'd0, 0, "t4.stall");
        chk("t4.locked", locked, 1);
        for (int i = 0; i < 30; i++) feed(i % 2 == 0, 3'd0, 0, "t4.run");

        // All-zero input never locks
        do_reset(1);
        for (int i = 0; i < 32; i++) step(1, 3'd0, 0, "t4.zero");
        chk("t4.zero_locked", locked, 0);

        // Saturation and clear priority
        do_reset(1);
        for (int i = 0; i < 8; i++) feed(1, 3'd0, 0, "t5.fill");
        for (int i = 0; i < 20; i++) begin
            feed(1, 3'(($urandom_range(0, 6)) + 1), 0, "t5.bad");
            feed(1, 3'd0, 0, "t5.ok1");
            feed(1, 3'd0, 0, "t5.ok2");
        end
        chk("t5.sat", err_cnt, 15);
        feed(1, 3'b010, 1, "t5.clr_bad");
        chk("t5.clr_cnt", err_cnt, 0);
        chk("t5.clr_err", err, 1);

        // Randomized traffic
        do_reset(1);
        for (int i = 0; i < 2000; i++) begin
            bit v;
            logic [2:0] m;
            bit c;
            v = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            c = ($urandom_range(0, 59) == 0);
            feed(v, m, c, "rnd");
        end

        // Async reset mid-cycle while locked
        do_reset(1);
        for (int i = 0; i < 12; i++) feed(1, 3'd0, 0, "t6.fill");
        feed(1, 3'b001, 0, "t6.bad");
        chk("t6.pre_err", err, 1);
        #3 Rst = 1;
        #1;
        chk("t6.locked", locked, 0);
        chk("t6.err", err, 0);
        chk("t6.err_cnt", err_cnt, 0);
        @(posedge Clk);
        #1 Rst = 0;
        model_reset();
        for (int i = 0; i < 7; i++) feed(1, 3'd0, 0, "t6.refill");
        chk("t6.not_yet", locked, 0);
        feed(1, 3'd0, 0, "t6.refill8");
        chk("t6.relock", locked, 1);
        for (int i = 0; i < 5; i++) feed(1, 3'd0, 0, "t6.clean");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
